// File: rtl/stride_scatter.sv
// Serial-in scatter loader: input bit k lands at out_word[k*STRIDE] and every
// other position is tied to FILL. The full word is offered on a valid/ready output.
module stride_scatter #(
    parameter int unsigned LEN    = 8,
    parameter int unsigned STRIDE = 2,
    parameter logic        FILL   = 1'b0,
    localparam int unsigned N     = LEN / STRIDE,
    localparam int unsigned CW    = ($clog2(N + 1) > 1) ? $clog2(N + 1) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_bit,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [LEN-1:0] out_word,
    output logic [CW-1:0]  bit_count
);

    typedef enum logic {COLLECT, FULL} state_t;

    state_t         state;
    logic [N-1:0]   stride_bits;

    // Collect N bits, hold the word until it is consumed; clear acts like reset.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= COLLECT;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            bit_count   <= '0;
            stride_bits <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        for (int k = 0; k < N; k++) begin
                            if (bit_count == CW'(k)) begin
                                stride_bits[k] <= in_bit;
                            end
                        end
                        bit_count <= bit_count + CW'(1);
                        if (bit_count == CW'(N - 1)) begin
                            state     <= FULL;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state       <= COLLECT;
                        in_ready    <= 1'b1;
                        out_valid   <= 1'b0;
                        bit_count   <= '0;
                        stride_bits <= '0;
                    end
                end
                default: begin
                    state       <= COLLECT;
                    in_ready    <= 1'b1;
                    out_valid   <= 1'b0;
                    bit_count   <= '0;
                    stride_bits <= '0;
                end
            endcase
        end
    end

    // Gap positions are constants, so only the stride positions carry flops.
    for (genvar i = 0; i < LEN; i++) begin : g_word
        if ((i % STRIDE) == 0) begin : g_stride
            assign out_word[i] = stride_bits[i / STRIDE];
        end else begin : g_gap
            assign out_word[i] = FILL;
        end
    end

endmodule

// File: tb/tb_stride_scatter.sv
// Bench for stride_scatter: three configurations share one stimulus stream and
// are checked every cycle against a bit-list model plus literal expectations.
module tb_stride_scatter;

    logic clk = 1'b0;
    logic rst, clear, in_valid, in_bit, out_ready;

    logic       ir [3];
    logic       ov [3];
    logic [7:0] ow0, ow1;
    logic [8:0] ow2;
    logic [2:0] bc0, bc1;
    logic [1:0] bc2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    localparam int MLEN  [3] = '{8, 8, 9};
    localparam int MSTR  [3] = '{2, 2, 3};
    localparam int MN    [3] = '{4, 4, 3};
    localparam bit MFILL [3] = '{1'b0, 1'b1, 1'b0};

    // Model: list of accepted bits (acc[j][k] = k-th bit), its length, and a full flag.
    logic [8:0] acc  [3];
    int         cnt  [3];
    bit         full [3];

    stride_scatter #(.LEN(8), .STRIDE(2), .FILL(1'b0)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir[0]),
        .in_bit(in_bit), .out_valid(ov[0]), .out_ready(out_ready), .out_word(ow0),
        .bit_count(bc0));
    stride_scatter #(.LEN(8), .STRIDE(2), .FILL(1'b1)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir[1]),
        .in_bit(in_bit), .out_valid(ov[1]), .out_ready(out_ready), .out_word(ow1),
        .bit_count(bc1));
    stride_scatter #(.LEN(9), .STRIDE(3), .FILL(1'b0)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir[2]),
        .in_bit(in_bit), .out_valid(ov[2]), .out_ready(out_ready), .out_word(ow2),
        .bit_count(bc2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] expand(input int j);
        logic [8:0] w;
        w = '0;
        for (int i = 0; i < MLEN[j]; i++)
            w[i] = ((i % MSTR[j]) == 0) ? acc[j][i / MSTR[j]] : MFILL[j];
        return w;
    endfunction

    function automatic logic [8:0] gap_mask(input int j);
        logic [8:0] m;
        m = '0;
        for (int i = 0; i < MLEN[j]; i++)
            m[i] = ((i % MSTR[j]) != 0);
        return m;
    endfunction

    function automatic logic [8:0] dut_word(input int j);
        return (j == 0) ? 9'(ow0) : (j == 1) ? 9'(ow1) : ow2;
    endfunction

    function automatic logic [31:0] dut_count(input int j);
        return (j == 0) ? 32'(bc0) : (j == 1) ? 32'(bc1) : 32'(bc2);
    endfunction

    // Reference model update on each rising edge.
    always @(posedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (rst || clear) begin
                full[j] <= 1'b0;
                cnt[j]  <= 0;
                acc[j]  <= '0;
            end else if (!full[j]) begin
                if (in_valid) begin
                    acc[j][cnt[j]] <= in_bit;
                    cnt[j]         <= cnt[j] + 1;
                    full[j]        <= (cnt[j] + 1 == MN[j]);
                end
            end else if (out_ready) begin
                full[j] <= 1'b0;
                cnt[j]  <= 0;
                acc[j]  <= '0;
            end
        end
    end

    // Every-cycle comparison; stride bits only matter while the word is valid.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 3; j++) begin
                logic [8:0] m;
                m = full[j] ? 9'((1 << MLEN[j]) - 1) : gap_mask(j);
                chk($sformatf("u%0d.in_ready", j), 32'(ir[j]), 32'(!full[j]));
                chk($sformatf("u%0d.out_valid", j), 32'(ov[j]), 32'(full[j]));
                chk($sformatf("u%0d.bit_count", j), dut_count(j), 32'(cnt[j]));
                chk($sformatf("u%0d.out_word", j), 32'(dut_word(j) & m), 32'(expand(j) & m));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        int words;
        logic [2:0] dec;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;

        // Reset values
        chk("reset.word_fill0", 32'(ow0), 32'h00);
        chk("reset.word_fill1", 32'(ow1), 32'hAA);
        chk("reset.word_len9", 32'(ow2), 32'h000);
        chk("reset.in_ready", 32'(ir[0]), 32'd1);
        chk("reset.out_valid", 32'(ov[0]), 32'd0);
        chk("reset.bit_count", 32'(bc0), 32'd0);

        // Load 1,0,1,1 back to back
        feed(1'b1); feed(1'b0); feed(1'b1);
        chk("load.valid_early", 32'(ov[0]), 32'd0);
        feed(1'b1);
        chk("load.valid_cycle5", 32'(ov[0]), 32'd1);
        chk("load.word_fill0", 32'(ow0), 32'h51);
        chk("load.word_fill1", 32'(ow1), 32'hFB);
        chk("load.bit_count", 32'(bc0), 32'd4);

        // Backpressure with in_valid high and toggling bits
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_bit = 1'(i);
            cyc();
            chk("bp.out_valid", 32'(ov[0]), 32'd1);
            chk("bp.out_word", 32'(ow0), 32'h51);
            chk("bp.in_ready", 32'(ir[0]), 32'd0);
        end
        in_valid = 1'b0;
        drain();
        chk("bp.release_valid", 32'(ov[0]), 32'd0);
        chk("bp.release_ready", 32'(ir[0]), 32'd1);
        chk("bp.release_count", 32'(bc0), 32'd0);

        // LEN=9 STRIDE=3
        do_reset();
        feed(1'b1); feed(1'b1); feed(1'b1);
        dec = {ow2[6], ow2[3], ow2[0]};
        chk("len9.out_valid", 32'(ov[2]), 32'd1);
        chk("len9.out_word", 32'(ow2), 32'h049);
        chk("len9.decimate", 32'(dec), 32'b111);
        drain();

        // Abort with clear, then with rst; a handshake during abort is dropped
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            feed(1'b1); feed(1'b1);
            in_valid = 1'b1; in_bit = 1'b1;
            if (pass == 0) clear = 1'b1; else rst = 1'b1;
            cyc();
            clear = 1'b0; rst = 1'b0; in_valid = 1'b0;
            chk("abort.in_ready", 32'(ir[0]), 32'd1);
            chk("abort.bit_count", 32'(bc0), 32'd0);
            feed(1'b0); feed(1'b0); feed(1'b1); feed(1'b0);
            chk("abort.out_valid", 32'(ov[0]), 32'd1);
            chk("abort.out_word", 32'(ow0), 32'h10);
            drain();
        end

        // Gapped input: valid every third cycle, random bits and backpressure
        do_reset();
        words = 0;
        for (int c = 0; c < 3000 && words < 20; c++) begin
            in_valid  = ((c % 3) == 0);
            in_bit    = 1'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            if (ov[0] && out_ready) words++;
            cyc();
        end
        chk("gapped.word_budget", 32'(words), 32'd20);

        // Fully random traffic with occasional clear and reset
        for (int c = 0; c < 600; c++) begin
            in_valid  = 1'($urandom);
            in_bit    = 1'($urandom);
            out_ready = 1'($urandom);
            clear     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            cyc();
        end
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stride_scatter.md
# stride_scatter

Serial-in scatter loader for the PAL configuration path. It accepts N = LEN/STRIDE bits over a valid/ready stream and places input bit k at position k·STRIDE of a LEN-bit word, filling the gap positions with a constant. When all N bits are loaded, it presents the expanded word on a valid/ready output. It is the inverse of stride decimation: taking every STRIDE-th bit of out_word returns the loaded bits in order.

## Interface
- LEN, 8: width of the expanded output word; must be a multiple of STRIDE.
- STRIDE, 2: spacing between loaded bit positions; ≥1.
- FILL, 1'b0: constant driven on every non-stride position (i % STRIDE != 0).
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous abort: discards partial or complete word, returns to COLLECT.
- in_valid  in  1  in_bit is valid this cycle.
- in_ready  out  1  block accepts in_bit this cycle.
- in_bit  in  1  next serial bit, loaded in order k = 0 … N-1.
- out_valid  out  1  out_word holds a complete expanded word.
- out_ready  in  1  consumer takes out_word this cycle.
- out_word  out  LEN  expanded word.
- bit_count  out  max(1,$clog2(N+1))  number of bits accepted into the current word.

## Operation
- N = LEN/STRIDE. Stride positions are i = k·STRIDE for k = 0 … N-1. Gap positions are all other i.
- Gap positions of out_word are always FILL. They never change, including at reset.
- Two states:
  - COLLECT: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1.
- COLLECT: on in_valid & in_ready, out_word[bit_count·STRIDE] ← in_bit and bit_count += 1.
  - When the accepted bit is bit N-1, the next state is FULL and bit_count = N.
- FULL: out_word is frozen. in_valid is ignored (no accept).
  - On out_ready, the next state is COLLECT, bit_count ← 0, and stride positions ← 0.
- Stride positions of out_word update as bits arrive. They are meaningful only while out_valid=1.
- clear (state-independent) has the same effect as rst: state COLLECT, bit_count 0, stride positions 0.
- Priority: rst > clear > handshakes. A handshake in the same cycle as clear is dropped.
- N=1 case: each accepted bit goes straight to FULL.
- No bypass: a new word's first bit cannot be accepted in the cycle out_ready completes the previous word.

## Timing
- Reset values:
  - state COLLECT, in_ready=1, out_valid=0, bit_count=0.
  - out_word: stride positions 0, gap positions FILL.
- Bit accepted at edge t is visible on out_word and bit_count after edge t.
- Load latency: out_valid rises the cycle after the N-th handshake.
- Minimum word period: N+1 cycles, i.e. N accept cycles plus 1 FULL cycle with out_ready=1.
- in_ready is registered state, not combinationally dependent on in_valid or out_ready.
- out_valid stays high and out_word stays stable indefinitely while out_ready=0.
- rst or clear mid-word:
  - the partial word is lost.
  - in_ready=1 the next cycle.
  - the next accepted bit is k=0.

## Test plan
- LEN=8, STRIDE=2, FILL=0; feed 1,0,1,1 with in_valid held high → out_valid rises on cycle 5, out_word=8'h51, bit_count=4.
- Same bits with FILL=1 → out_word=8'hFB. Reset value of out_word=8'hAA.
- LEN=9, STRIDE=3, FILL=0; feed 1,1,1 → out_word=9'h049. Decimating out_word by 3 returns 3'b111.
- Backpressure: word complete, out_ready=0 for 5 cycles with in_valid=1 and in_bit toggling → out_valid stays 1, out_word unchanged, in_ready=0. Then out_ready=1 for one cycle → next cycle out_valid=0, in_ready=1, bit_count=0.
- Abort:
  - Feed 1,1 then assert clear, then feed 0,0,1,0 → out_word=8'h10; the earlier bits are absent.
  - Repeat with rst instead of clear → same result.
- Gapped input: in_valid high on every third cycle with random bits for 20 words (LEN=8, STRIDE=2) → each out_word matches the scatter model. Gap bits are never equal to !FILL.
